// File: rtl/nibble_serial_adder.sv
// Serial wide adder: streams one operand nibble per cycle through an external
// 4-bit adder, chaining the carry and assembling the W-bit result.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; the producer holds valid and data stable until it sees ready.
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   input  logic                   cin_in,
   output logic [3:0]             nib_a,
   output logic [3:0]             nib_b,
   output logic                   nib_cin,
   input  logic [3:0]             nib_sum,
   input  logic                   nib_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum_out,
   output logic                   cout_out,
   output logic                   ovf_out,
   output logic [1:0]             dbg_state
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    sum_q;
   logic [IW-1:0]   idx_q;
   logic            cout_q;
   logic            ovf_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [3:0]      nib_a_q;
   logic [3:0]      nib_b_q;
   logic            nib_cin_q;

   logic [IW-1:0]   idx_d;
   logic            last_d;
   logic [3:0]      nxt_a_d;
   logic [3:0]      nxt_b_d;
   logic            ovf_d;

   // Next nibble is preselected so the adder inputs come straight from flops.
   always_comb begin
      last_d  = (idx_q == LAST_IDX);
      idx_d   = last_d ? '0 : idx_q + IW'(1);
      nxt_a_d = a_q[4*idx_d +: 4];
      nxt_b_d = b_q[4*idx_d +: 4];
      ovf_d   = a_q[W-1] ^ b_q[W-1] ^ nib_sum[3] ^ nib_cout;
   end

   // nib_cin_q doubles as the inter-nibble carry register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         nib_a_q     <= '0;
         nib_b_q     <= '0;
         nib_cin_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a_in;
                  b_q        <= b_in;
                  sum_q      <= '0;
                  cout_q     <= 1'b0;
                  ovf_q      <= 1'b0;
                  idx_q      <= '0;
                  nib_a_q    <= a_in[3:0];
                  nib_b_q    <= b_in[3:0];
                  nib_cin_q  <= cin_in;
                  in_ready_q <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[4*idx_q +: 4] <= nib_sum;
               if (last_d) begin
                  cout_q      <= nib_cout;
                  ovf_q       <= ovf_d;
                  nib_a_q     <= '0;
                  nib_b_q     <= '0;
                  nib_cin_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end else begin
                  idx_q     <= idx_d;
                  nib_a_q   <= nxt_a_d;
                  nib_b_q   <= nxt_b_d;
                  nib_cin_q <= nib_cout;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign nib_a     = nib_a_q;
   assign nib_b     = nib_b_q;
   assign nib_cin   = nib_cin_q;
   assign sum_out   = sum_q;
   assign cout_out  = cout_q;
   assign ovf_out   = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4) with a behavioural nibble adder,
// a vector table, corner-case sequences and an in-order result scoreboard.
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          cin_in;
   logic [3:0]    nib_a;
   logic [3:0]    nib_b;
   logic          nib_cin;
   logic [3:0]    nib_sum;
   logic          nib_cout;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum_out;
   logic          cout_out;
   logic          ovf_out;
   logic [1:0]    dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W+1:0] exp_q[$];
   int           done_cyc[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[6];

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
      .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
      .nib_sum(nib_sum), .nib_cout(nib_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .cout_out(cout_out), .ovf_out(ovf_out),
      .dbg_state(dbg_state)
   );

   // Behavioural 4-bit nibble adder.
   assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, nib_cin};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      logic [W:0] t;
      logic       ovf;
      t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      return {ovf, t[W], t[W-1:0]};
   endfunction

   // Carry seen at each nibble's Cin, from a nibble-by-nibble long addition.
   function automatic logic [N-1:0] exp_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic c);
      logic [N-1:0] cs;
      logic [4:0]   t;
      logic         cc;
      cc = c;
      for (int i = 0; i < N; i++) begin
         cs[i] = cc;
         t  = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, cc};
         cc = t[4];
      end
      return cs;
   endfunction

   // Scoreboard: a result is consumed where out_valid and out_ready meet.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got result %0h expected none", sum_out);
         end else begin
            chk("sb_result", 64'({ovf_out, cout_out, sum_out}), 64'(exp_q.pop_front()));
            done_cyc.push_back(cyc);
         end
      end
   end

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_timeout", 64'(in_ready), 64'(1));
   endtask

   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output logic ov,
                          output int lat, output logic [N-1:0] carries);
      int k;
      int n;
      int ci;
      in_valid = 1'b1;
      a_in = a;
      b_in = b;
      cin_in = c;
      wait_in_ready();
      exp_q.push_back(model(a, b, c));
      k = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_in = W'($urandom);
      b_in = W'($urandom);
      cin_in = 1'($urandom_range(0, 1));
      carries = '0;
      ci = 0;
      n = 0;
      while (!out_valid && n < 50) begin
         if (dbg_state == 2'd1 && ci < N) begin
            carries[ci] = nib_cin;
            ci++;
         end
         @(posedge clk); #1;
         n++;
      end
      chk("out_valid_timeout", 64'(out_valid), 64'(1));
      lat = cyc - k;
      s = sum_out;
      co = cout_out;
      ov = ovf_out;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           lat;
      logic [N-1:0] cs;
      logic [W-1:0] held;
      logic         seen;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           n;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'h89AB, 16'h7655, 1'b1, 16'h0001, 1'b1, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a_in = '0;
      b_in = '0;
      cin_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_outputs", 64'({sum_out, cout_out, ovf_out}), 64'(0));
      chk("rst_nib", 64'({nib_a, nib_b, nib_cin}), 64'(0));

      // Reset and in_valid together: nothing may be accepted.
      in_valid = 1'b1;
      a_in = 16'h0F0F;
      b_in = 16'h0101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b0;
      chk("rst_vs_valid_state", 64'(dbg_state), 64'(0));
      chk("rst_vs_valid_ready", 64'(in_ready), 64'(1));

      for (int i = 0; i < 6; i++) begin
         run_one(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat, cs);
         chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
         chk($sformatf("vec%0d_cout", i), 64'(co), 64'(vecs[i].cout));
         chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
         chk($sformatf("vec%0d_carries", i), 64'(cs),
             64'(exp_carries(vecs[i].a, vecs[i].b, vecs[i].cin)));
      end

      // Back-pressure: result held, pending operands refused.
      in_valid = 1'b1;
      a_in = 16'h0F0F;
      b_in = 16'h00F1;
      cin_in = 1'b0;
      wait_in_ready();
      exp_q.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
      @(posedge clk); #1;
      a_in = 16'hAAAA;
      b_in = 16'h5555;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_sum", 64'(sum_out), 64'(16'h1000));
      held = sum_out;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 64'(out_valid), 64'(1));
         chk("bp_hold_sum", 64'(sum_out), 64'(held));
         chk("bp_hold_in_ready", 64'(in_ready), 64'(0));
         chk("bp_hold_state", 64'(dbg_state), 64'(2));
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_in_ready", 64'(in_ready), 64'(1));
      chk("bp_release_out_valid", 64'(out_valid), 64'(0));

      // Reset on the second RUN cycle discards the operation.
      in_valid = 1'b1;
      a_in = 16'h1111;
      b_in = 16'h2222;
      cin_in = 1'b0;
      wait_in_ready();
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_run_state", 64'(dbg_state), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_outputs", 64'({out_valid, sum_out, cout_out, ovf_out}), 64'(0));
      chk("mid_rst_nib", 64'({nib_a, nib_b, nib_cin}), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("mid_rst_no_valid", 64'(seen), 64'(0));
      run_one(16'h0001, 16'h0002, 1'b0, s, co, ov, lat, cs);
      chk("after_rst_sum", 64'({ov, co, s}), 64'(18'h00003));

      // Back-to-back stream with out_ready held high.
      done_cyc.delete();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         a_in = ra;
         b_in = rb;
         cin_in = rc;
         wait_in_ready();
         exp_q.push_back(model(ra, rb, rc));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      chk("stream_drained", 64'(exp_q.size()), 64'(0));
      chk("stream_count", 64'(done_cyc.size()), 64'(8));
      for (int i = 1; i < done_cyc.size(); i++)
         chk($sformatf("stream_spacing%0d", i), 64'(done_cyc[i] - done_cyc[i-1]), 64'(N + 2));

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
